// File: rtl/jesd204_tpl_dac_pkg.sv
// Shared definitions for the JESD204 TPL DAC path: DMA FIFO state encoding and width helpers.
package jesd204_tpl_dac_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PREFILL = 2'd1;
  localparam logic [1:0] STREAM  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = IDLE,
    S_PREFILL = PREFILL,
    S_STREAM  = STREAM
  } fifo_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Core link word width: NUM_LANES * OCTETS_PER_BEAT * 8.
  function automatic int link_data_width(input int num_lanes, input int octets_per_beat);
    return num_lanes * octets_per_beat * 8;
  endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_fifo_mem.sv
// Simple dual-port RAM with one write port and a registered, write-first read port.
module ad_ip_jesd204_tpl_dac_fifo_mem #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic                  clr_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Bypass lets a word written this edge become the head immediately when the FIFO ran dry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    rdata_q <= '0;
    else if (clr_i) rdata_q <= '0;
    else if (re_i)  rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_dma_fifo.sv
// Elastic prefill FIFO between the DAC DMA stream and the TPL DAC core, with sticky underflow.
// Optional DAC_FIFO_ZERO_ON_UNDERFLOW_EN zeroes dac_ddata on underflow instead of holding it.
module ad_ip_jesd204_tpl_dac_dma_fifo
  import jesd204_tpl_dac_pkg::*;
#(
  parameter int DATA_WIDTH    = 128,
  parameter int NUM_CHANNELS  = 1,
  parameter int ADDR_WIDTH    = 4,
  parameter int PREFILL_LEVEL = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    s_axis_valid,
  output logic                    s_axis_ready,
  input  logic [DATA_WIDTH-1:0]   s_axis_data,
  input  logic [NUM_CHANNELS-1:0] dac_valid,
  output logic [DATA_WIDTH-1:0]   dac_ddata,
  output logic                    dac_dunf,
  input  logic                    dac_dunf_clr,
  output logic [ADDR_WIDTH:0]     fifo_level
);

  localparam int              LW          = ADDR_WIDTH + 1;
  localparam logic [LW-1:0]   FULL_LVL    = LW'(2**ADDR_WIDTH);
  localparam logic [LW-1:0]   PREFILL_LVL = LW'(PREFILL_LEVEL);

  fifo_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  dunf_q, dunf_d, ready_q;
  logic                  push, pop, underflow, rd_en, rd_clr;
  logic                  dac_valid_unused;

  // All dac_valid bits are identical; bit 0 is the request.
  assign dac_valid_unused = ^dac_valid;

  always_comb begin
    push      = s_axis_valid & ready_q;
    pop       = dac_valid[0] & (state_q == S_STREAM) & (level_q != '0);
    underflow = dac_valid[0] & (state_q == S_STREAM) & (level_q == '0);
    wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(pop);
    level_d   = level_q + LW'(push) - LW'(pop);
    dunf_d    = underflow | (dunf_q & ~dac_dunf_clr);
    state_d   = state_q;
    case (state_q)
      S_IDLE:    if (push) state_d = S_PREFILL;
      S_PREFILL: if (level_q >= PREFILL_LVL) state_d = S_STREAM;
      S_STREAM:  if (underflow) state_d = S_PREFILL;
      default:   state_d = S_IDLE;
    endcase
    // Refresh the head only while streaming with data; otherwise the last popped word is held.
    rd_en = (state_d == S_STREAM) && (level_d != '0);
  end

`ifdef DAC_FIFO_ZERO_ON_UNDERFLOW_EN
  assign rd_clr = underflow;
`else
  assign rd_clr = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dunf_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dunf_q   <= dunf_d;
      ready_q  <= (level_d != FULL_LVL);
    end
  end

  ad_ip_jesd204_tpl_dac_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .resetn  (resetn),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (s_axis_data),
    .re_i    (rd_en),
    .clr_i   (rd_clr),
    .raddr_i (rd_ptr_d),
    .rdata_o (dac_ddata)
  );

  assign s_axis_ready = ready_q;
  assign dac_dunf     = dunf_q;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_dma_fifo.sv
// Self-checking bench for the DAC DMA FIFO: vector table, corner sequences, random vs queue model.
`timescale 1ns/1ps
module tb_ad_ip_jesd204_tpl_dac_dma_fifo;

  localparam int DW    = 128;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int PFL   = 8;
`ifdef DAC_FIFO_ZERO_ON_UNDERFLOW_EN
  localparam bit ZERO_UF = 1'b1;
`else
  localparam bit ZERO_UF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          s_axis_valid = 1'b0;
  logic          s_axis_ready;
  logic [DW-1:0] s_axis_data = '0;
  logic [0:0]    dac_valid = '0;
  logic [DW-1:0] dac_ddata;
  logic          dac_dunf;
  logic          dac_dunf_clr = 1'b0;
  logic [AW:0]   fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_dma_fifo #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(1), .ADDR_WIDTH(AW), .PREFILL_LEVEL(PFL)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready), .s_axis_data(s_axis_data),
    .dac_valid(dac_valid), .dac_ddata(dac_ddata), .dac_dunf(dac_dunf),
    .dac_dunf_clr(dac_dunf_clr), .fifo_level(fifo_level)
  );

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          dv;
    logic          clr;
    logic [AW:0]   lvl;
    logic          rdy;
    logic [DW-1:0] dd;
    logic          unf;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic v, input int d, input logic dv, input logic clr,
                              input int lvl, input logic rdy, input int dd, input logic unf);
    vec_t r;
    r.v = v; r.d = DW'(d); r.dv = dv; r.clr = clr;
    r.lvl = (AW+1)'(lvl); r.rdy = rdy; r.dd = DW'(dd); r.unf = unf;
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, return at the next falling edge.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic dv, input logic clr);
    s_axis_valid = v; s_axis_data = d; dac_valid[0] = dv; dac_dunf_clr = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    s_axis_valid = 1'b0; dac_valid = '0; dac_dunf_clr = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_level", DW'(fifo_level), '0);
    chk("rst_ready", DW'(s_axis_ready), '0);
    chk("rst_ddata", dac_ddata, '0);
    chk("rst_dunf",  DW'(dac_dunf), '0);
    resetn = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("post_rst_ready", DW'(s_axis_ready), DW'(1));
  endtask

  // Random traffic against a queue-based model of the FIFO's documented behaviour.
  task automatic run_random(input int ncyc);
    logic [DW-1:0] q[$];
    logic [DW-1:0] shown, d, exp_dd;
    int st, oldsize, pv, pd;
    logic v, dv, clr, push, pop, uf, mdunf;
    q.delete(); st = 0; mdunf = 1'b0; shown = '0; pv = 50; pd = 50;
    for (int n = 0; n < ncyc && errors < 20; n++) begin
      if (n % 400 == 0) begin
        pv = $urandom_range(10, 90);
        pd = $urandom_range(10, 90);
      end
      v   = ($urandom % 100) < pv;
      dv  = ($urandom % 100) < pd;
      clr = ($urandom % 50) == 0;
      d   = {$urandom, $urandom, $urandom, $urandom};
      exp_dd = (st == 2 && q.size() > 0) ? q[0] : shown;
      chk("rnd_level", DW'(fifo_level), DW'(q.size()));
      chk("rnd_ready", DW'(s_axis_ready), DW'(q.size() != DEPTH));
      chk("rnd_dunf",  DW'(dac_dunf), DW'(mdunf));
      chk("rnd_ddata", dac_ddata, exp_dd);
      push = v && (q.size() != DEPTH);
      pop  = dv && st == 2 && q.size() != 0;
      uf   = dv && st == 2 && q.size() == 0;
      oldsize = q.size();
      if (pop) shown = q.pop_front();
      if (push) q.push_back(d);
      if (uf) begin
        mdunf = 1'b1;
        if (ZERO_UF) shown = '0;
      end else if (clr) mdunf = 1'b0;
      case (st)
        0: if (push) st = 1;
        1: if (oldsize >= PFL) st = 2;
        default: if (uf) st = 1;
      endcase
      cyc(v, d, dv, clr);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = mk(1, i + 1, 1, 0, i + 1, 1, 0, 0);
    tbl[8]  = mk(0, 0, 1, 0, 8, 1, 1, 0);
    tbl[9]  = mk(0, 0, 1, 0, 7, 1, 2, 0);
    tbl[10] = mk(0, 0, 1, 0, 6, 1, 3, 0);
    tbl[11] = mk(1, 9, 1, 0, 6, 1, 4, 0);
    tbl[12] = mk(0, 0, 0, 0, 6, 1, 4, 0);
    tbl[13] = mk(0, 0, 1, 0, 5, 1, 5, 0);

    // Prefill then stream in order, with a sync-hold cycle.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].dv, tbl[i].clr);
      chk($sformatf("tbl%0d_level", i), DW'(fifo_level), DW'(tbl[i].lvl));
      chk($sformatf("tbl%0d_ready", i), DW'(s_axis_ready), DW'(tbl[i].rdy));
      chk($sformatf("tbl%0d_ddata", i), dac_ddata, tbl[i].dd);
      chk($sformatf("tbl%0d_dunf", i),  DW'(dac_dunf), DW'(tbl[i].unf));
    end

    // Fill to full, then push+pop at the boundary and drain in order.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, DW'(i + 1), 1'b0, 1'b0);
    chk("full_level", DW'(fifo_level), DW'(16));
    chk("full_ready", DW'(s_axis_ready), '0);
    chk("full_head",  dac_ddata, DW'(1));
    cyc(1'b1, DW'(17), 1'b1, 1'b0);
    chk("full_pop_level", DW'(fifo_level), DW'(15));
    chk("full_pop_ready", DW'(s_axis_ready), DW'(1));
    chk("full_pop_head",  dac_ddata, DW'(2));
    cyc(1'b1, DW'(17), 1'b1, 1'b0);
    chk("pushpop_level", DW'(fifo_level), DW'(15));
    for (int k = 3; k <= 17; k++) begin
      chk($sformatf("drain_%0d", k), dac_ddata, DW'(k));
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    chk("empty_level", DW'(fifo_level), '0);
    chk("empty_hold",  dac_ddata, DW'(17));
    chk("empty_dunf",  DW'(dac_dunf), '0);

    // Underflow: sticky flag, back to prefill.
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("uf_dunf",  DW'(dac_dunf), DW'(1));
    chk("uf_ddata", dac_ddata, ZERO_UF ? '0 : DW'(17));
    cyc(1'b1, DW'('h21), 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("uf_prefill_nopop", DW'(fifo_level), DW'(1));
    chk("uf_prefill_ddata", dac_ddata, ZERO_UF ? '0 : DW'(17));
    chk("uf_dunf_sticky", DW'(dac_dunf), DW'(1));

    // Clear, then clear coinciding with a fresh underflow.
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("clr_dunf", DW'(dac_dunf), '0);
    for (int i = 2; i <= 8; i++) cyc(1'b1, DW'('h20 + i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("restream_head", dac_ddata, DW'('h21));
    for (int k = 'h21; k <= 'h28; k++) begin
      chk($sformatf("restream_%0h", k), dac_ddata, DW'(k));
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("set_wins", DW'(dac_dunf), DW'(1));
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("clr_alone", DW'(dac_dunf), '0);

    // Asynchronous reset mid-stream at level 5, then restart from idle.
    for (int i = 0; i < 8; i++) cyc(1'b1, DW'('h41 + i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("mid_level", DW'(fifo_level), DW'(5));
    chk("mid_ddata", dac_ddata, DW'('h44));
    #2 resetn = 1'b0;
    #1;
    chk("async_level", DW'(fifo_level), '0);
    chk("async_ddata", dac_ddata, '0);
    chk("async_ready", DW'(s_axis_ready), '0);
    @(negedge clk);
    resetn = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, DW'('h51 + i), 1'b1, 1'b0);
      chk($sformatf("refill_%0d_level", i), DW'(fifo_level), DW'(i + 1));
      chk($sformatf("refill_%0d_ddata", i), dac_ddata, '0);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("refill_head", dac_ddata, DW'('h51));
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("refill_next", dac_ddata, DW'('h52));

    do_reset();
    run_random(20000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
